// File: rtl/imem_loader.sv
// Byte-stream to instruction-memory loader: packs little-endian bytes into 32-bit words.
// Optional running sum of written words is enabled by defining LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned DEPTH = 1000
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    input  logic        in_last,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        overflow,
    output logic [15:0] word_count,
    output logic [31:0] checksum
);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e      state_q;
    logic [31:0] idx_q;
    logic [1:0]  lane_q;
    logic [31:0] word_q;
    logic [31:0] merged;
    logic        accept;

    assign accept = in_valid && in_ready;

    // Current partial word with the incoming byte dropped into its lane; upper lanes stay zero.
    always_comb begin
        merged = word_q;
        merged[{lane_q, 3'b000} +: 8] = in_byte;
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            lane_q     <= '0;
            word_q     <= '0;
            in_ready   <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
        end else begin
            wr_en <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q    <= StLoad;
                        in_ready   <= 1'b1;
                        cpu_hold   <= 1'b1;
                        done       <= 1'b0;
                        idx_q      <= '0;
                        lane_q     <= '0;
                        word_q     <= '0;
                        overflow   <= 1'b0;
                        word_count <= '0;
                    end
                end
                StLoad: begin
                    if (accept) begin
                        if (idx_q == DEPTH) begin
                            overflow <= 1'b1;
                        end else if (lane_q == 2'd3 || in_last) begin
                            wr_en      <= 1'b1;
                            wr_addr    <= idx_q << 2;
                            wr_data    <= merged;
                            idx_q      <= idx_q + 32'd1;
                            word_count <= word_count + 16'd1;
                            lane_q     <= '0;
                            word_q     <= '0;
                        end else begin
                            word_q <= merged;
                            lane_q <= lane_q + 2'd1;
                        end
                        if (in_last) begin
                            state_q  <= StDone;
                            in_ready <= 1'b0;
                            cpu_hold <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] checksum_q;

    // Accumulates the word one cycle after its strobe; a new load restarts the sum.
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            checksum_q <= '0;
        end else if (start && state_q != StLoad) begin
            checksum_q <= '0;
        end else if (wr_en) begin
            checksum_q <= checksum_q + wr_data;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 32'd0;
`endif

endmodule
